// File: rtl/ofdm_rx_pkg.sv
// Shared OFDM constants and the RATE-field decoder.
// The TX puncturer reuses the same RATE codes and puncture-rate enum.
package ofdm_rx_pkg;

  // RATE field codes, one per data rate in Mb/s
  localparam logic [3:0] RATE_6M  = 4'b1101;
  localparam logic [3:0] RATE_9M  = 4'b1111;
  localparam logic [3:0] RATE_12M = 4'b0101;
  localparam logic [3:0] RATE_18M = 4'b0111;
  localparam logic [3:0] RATE_24M = 4'b1001;
  localparam logic [3:0] RATE_36M = 4'b1011;
  localparam logic [3:0] RATE_48M = 4'b0001;
  localparam logic [3:0] RATE_54M = 4'b0011;

  // Neutral soft value inserted at punctured positions
  localparam int ERASE_VAL = 0;

  typedef enum logic [1:0] {R12, R23, R34} rate_e;

  // SIGNAL symbols are always rate 1/2; unknown codes fall back to 1/2.
  function automatic rate_e rate_decode(input logic [3:0] rate_con,
                                        input logic       signal_flag);
    rate_e r;
    r = R12;
    if (!signal_flag) begin
      case (rate_con)
        RATE_6M, RATE_12M, RATE_24M:           r = R12;
        RATE_9M, RATE_18M, RATE_36M, RATE_54M: r = R34;
        RATE_48M:                              r = R23;
        default:                               r = R12;
      endcase
    end
    return r;
  endfunction

endpackage

// File: rtl/data_depuncturing.sv
// Depuncturer: rebuilds the rate-1/2 (A,B) soft-bit pair stream from the
// punctured stream, inserting erasures where the transmitter dropped bits.
module data_depuncturing
  import ofdm_rx_pkg::*;
#(
  parameter int SOFT_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        rate_con,
  input  logic              signal_flag_in,
  input  logic              frame_start,
  input  logic [SOFT_W-1:0] din,
  input  logic              din_valid,
  input  logic              din_last,
  output logic              din_ready,
  output logic [SOFT_W-1:0] dout_a,
  output logic [SOFT_W-1:0] dout_b,
  output logic [1:0]        dout_erase,
  output logic              dout_valid,
  output logic              dout_last,
  input  logic              dout_ready,
  output logic              signal_flag_out
);

  localparam logic [SOFT_W-1:0] ERASE = SOFT_W'(ERASE_VAL);

  // Group state: pair index within the group, one-bit collector, latched rate
  logic [1:0]        phase_q;
  logic              coll_vld_q;
  logic [SOFT_W-1:0] coll_q;
  rate_e             rate_q;
  logic              sig_q;

  // Next-state / pair-building signals
  logic              accept;
  logic              grp_start;
  logic [1:0]        cur_phase;
  logic              cur_cv;
  rate_e             cur_rate;
  logic              cur_sig;
  logic              emit;
  logic [SOFT_W-1:0] pair_a, pair_b;
  logic [1:0]        pair_e;
  logic [1:0]        nxt_phase;
  logic              nxt_cv;
  logic [SOFT_W-1:0] nxt_coll;

  // Single output register: a new bit is taken whenever the register can be
  // refilled in the same cycle, so a drain and a load never leave a bubble.
  assign din_ready = ~dout_valid | dout_ready;
  assign accept    = din_valid & din_ready;

  // Decide what the accepted bit does under the (rate, phase) schedule
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned
    // (an unassigned path would infer a latch).
    cur_phase = frame_start ? 2'd0 : phase_q;
    cur_cv    = frame_start ? 1'b0 : coll_vld_q;
    grp_start = (cur_phase == 2'd0) && !cur_cv;
    cur_rate  = grp_start ? rate_decode(rate_con, signal_flag_in) : rate_q;
    cur_sig   = grp_start ? signal_flag_in : sig_q;
    emit      = 1'b0;
    pair_a    = ERASE;
    pair_b    = ERASE;
    pair_e    = 2'b00;
    nxt_phase = cur_phase;
    nxt_cv    = cur_cv;
    nxt_coll  = coll_q;

    case (cur_phase)
      2'd0: begin
        if (cur_cv) begin
          // (A0,B0): collector holds A, this bit is B
          emit      = 1'b1;
          pair_a    = coll_q;
          pair_b    = din;
          nxt_cv    = 1'b0;
          nxt_phase = (cur_rate == R12) ? 2'd0 : 2'd1;
        end else begin
          nxt_cv   = 1'b1;
          nxt_coll = din;
          if (din_last) begin
            // Frame ends on a lone A: close the pair with an erased B
            emit   = 1'b1;
            pair_a = din;
            pair_e = 2'b01;
          end
        end
      end
      2'd1: begin
        // (A1,e): B1 was punctured
        emit      = 1'b1;
        pair_a    = din;
        pair_e    = 2'b01;
        nxt_phase = (cur_rate == R34) ? 2'd2 : 2'd0;
      end
      default: begin
        // (e,B2): A2 was punctured
        emit      = 1'b1;
        pair_b    = din;
        pair_e    = 2'b10;
        nxt_phase = 2'd0;
      end
    endcase

    // The last bit always closes the group; remaining pairs are not produced
    if (din_last) begin
      nxt_phase = 2'd0;
      nxt_cv    = 1'b0;
    end
  end

  // Advance group state on accepted bits; frame_start alone clears it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge value regardless of statement order.
      phase_q    <= 2'd0;
      coll_vld_q <= 1'b0;
      coll_q     <= '0;
      rate_q     <= R12;
      sig_q      <= 1'b0;
    end else if (accept) begin
      phase_q    <= nxt_phase;
      coll_vld_q <= nxt_cv;
      coll_q     <= nxt_coll;
      if (grp_start) begin
        rate_q <= cur_rate;
        sig_q  <= cur_sig;
      end
    end else if (frame_start) begin
      phase_q    <= 2'd0;
      coll_vld_q <= 1'b0;
      rate_q     <= R12;
      sig_q      <= 1'b0;
    end
  end

  // Output pair register: load on a completing accept, clear when drained
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_valid      <= 1'b0;
      dout_a          <= '0;
      dout_b          <= '0;
      dout_erase      <= 2'b00;
      dout_last       <= 1'b0;
      signal_flag_out <= 1'b0;
    end else if (accept && emit) begin
      dout_valid      <= 1'b1;
      dout_a          <= pair_a;
      dout_b          <= pair_b;
      dout_erase      <= pair_e;
      dout_last       <= din_last;
      signal_flag_out <= cur_sig;
    end else if (dout_ready) begin
      dout_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_data_depuncturing.sv
// Self-checking bench for data_depuncturing: directed scenarios followed by
// randomized traffic, all checked against a puncture-mask reference model.
module tb_data_depuncturing;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] rate_con;
  logic       signal_flag_in;
  logic       frame_start;
  logic [2:0] din;
  logic       din_valid;
  logic       din_last;
  logic       din_ready;
  logic [2:0] dout_a;
  logic [2:0] dout_b;
  logic [1:0] dout_erase;
  logic       dout_valid;
  logic       dout_last;
  logic       dout_ready;
  logic       signal_flag_out;

  int checks = 0;
  int errors = 0;

  data_depuncturing #(.SOFT_W(3)) dut (
    .clk             (clk),
    .rst             (rst),
    .rate_con        (rate_con),
    .signal_flag_in  (signal_flag_in),
    .frame_start     (frame_start),
    .din             (din),
    .din_valid       (din_valid),
    .din_last        (din_last),
    .din_ready       (din_ready),
    .dout_a          (dout_a),
    .dout_b          (dout_b),
    .dout_erase      (dout_erase),
    .dout_valid      (dout_valid),
    .dout_last       (dout_last),
    .dout_ready      (dout_ready),
    .signal_flag_out (signal_flag_out)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // A group is the mother-code slot sequence A0 B0 A1 B1 A2 B2 with a keep
  // mask per rate (0 = 1/2, 1 = 2/3, 2 = 3/4). Received bits fill kept slots
  // in order; a pair is released once all its kept slots are filled.
  int         g_rate;
  logic       g_sig;
  logic [2:0] g_bits[$];
  int         g_emitted;

  logic       m_valid;
  logic [2:0] m_a, m_b;
  logic [1:0] m_e;
  logic       m_l, m_s;

  function automatic int model_rate(input logic [3:0] rc, input logic sf);
    if (sf) return 0;
    case (rc)
      4'b1111, 4'b0111, 4'b1011, 4'b0011: return 2;
      4'b0001:                            return 1;
      default:                            return 0;
    endcase
  endfunction

  function automatic bit kept(input int r, input int s);
    case (r)
      0:       return s < 2;
      1:       return s < 3;
      default: return (s < 3) || (s == 5);
    endcase
  endfunction

  function automatic int kept_before(input int r, input int s);
    int n = 0;
    for (int i = 0; i < s; i++) if (kept(r, i)) n++;
    return n;
  endfunction

  task automatic group_clear();
    g_bits.delete();
    g_emitted = 0;
  endtask

  task automatic model_accept(input logic [2:0] bit_in, input logic [3:0] rc,
                              input logic sf, input logic fs, input logic last,
                              output logic got, output logic [2:0] pa,
                              output logic [2:0] pb, output logic [1:0] pe,
                              output logic pl, output logic ps);
    int p, need;
    logic [2:0] v[2];
    logic [1:0] er;
    got = 1'b0; pa = 3'd0; pb = 3'd0; pe = 2'b00; pl = 1'b0; ps = 1'b0;
    if (fs) group_clear();
    if (g_bits.size() == 0) begin
      g_rate = model_rate(rc, sf);
      g_sig  = sf;
    end
    g_bits.push_back(bit_in);
    p    = g_emitted;
    need = kept_before(g_rate, 2 * p + 2);
    if (g_bits.size() == need || last) begin
      for (int k = 0; k < 2; k++) begin
        int s, kb;
        s  = 2 * p + k;
        kb = kept_before(g_rate, s);
        if (kept(g_rate, s) && kb < g_bits.size()) begin
          v[k]     = g_bits[kb];
          er[1-k]  = 1'b0;
        end else begin
          v[k]     = 3'd0;
          er[1-k]  = 1'b1;
        end
      end
      got = 1'b1; pa = v[0]; pb = v[1]; pe = er; pl = last; ps = g_sig;
      g_emitted++;
      if (g_emitted == g_rate + 1 || last) group_clear();
    end
  endtask

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic check_outputs();
    check("dout_valid", {7'd0, dout_valid}, {7'd0, m_valid});
    if (m_valid) begin
      check("dout_a",     {5'd0, dout_a},          {5'd0, m_a});
      check("dout_b",     {5'd0, dout_b},          {5'd0, m_b});
      check("dout_erase", {6'd0, dout_erase},      {6'd0, m_e});
      check("dout_last",  {7'd0, dout_last},       {7'd0, m_l});
      check("sig_out",    {7'd0, signal_flag_out}, {7'd0, m_s});
    end
  endtask

  // One clock: inputs already driven; checks ready, then outputs after the edge
  task automatic tick();
    logic exp_rdy, acc, drn, got, pl, ps;
    logic [2:0] pa, pb;
    logic [1:0] pe;
    #2;
    exp_rdy = !m_valid || dout_ready;
    check("din_ready", {7'd0, din_ready}, {7'd0, exp_rdy});
    acc = din_valid && exp_rdy;
    drn = m_valid && dout_ready;
    @(posedge clk); #1;
    got = 1'b0;
    if (acc) model_accept(din, rate_con, signal_flag_in, frame_start, din_last,
                          got, pa, pb, pe, pl, ps);
    else if (frame_start) group_clear();
    if (got) begin
      m_valid = 1'b1; m_a = pa; m_b = pb; m_e = pe; m_l = pl; m_s = ps;
    end else if (drn) begin
      m_valid = 1'b0;
    end
    check_outputs();
  endtask

  task automatic send(input logic [2:0] v, input logic last);
    din_valid = 1'b1; din = v; din_last = last;
    tick();
    din_valid = 1'b0; din_last = 1'b0; frame_start = 1'b0;
  endtask

  task automatic check_reset_outputs();
    check("rst_valid", {7'd0, dout_valid},      8'd0);
    check("rst_ready", {7'd0, din_ready},       8'd1);
    check("rst_a",     {5'd0, dout_a},          8'd0);
    check("rst_b",     {5'd0, dout_b},          8'd0);
    check("rst_erase", {6'd0, dout_erase},      8'd0);
    check("rst_last",  {7'd0, dout_last},       8'd0);
    check("rst_sig",   {7'd0, signal_flag_out}, 8'd0);
  endtask

  initial begin
    rst = 1'b1; rate_con = 4'b1101; signal_flag_in = 1'b0; frame_start = 1'b0;
    din = 3'd0; din_valid = 1'b0; din_last = 1'b0; dout_ready = 1'b1;
    m_valid = 1'b0; m_a = '0; m_b = '0; m_e = '0; m_l = 1'b0; m_s = 1'b0;
    g_rate = 0; g_sig = 1'b0; group_clear();
    #12;
    check_reset_outputs();
    rst = 1'b0;
    tick();

    // Rate 1/2: (1,2,00), (3,4,00)
    rate_con = 4'b1101;
    send(3'd1, 0); send(3'd2, 0); send(3'd3, 0); send(3'd4, 0);
    tick();

    // Rate 3/4: (1,2,00), (3,0,01), (0,4,10), then 5 opens a new group
    rate_con = 4'b1111;
    send(3'd1, 0); send(3'd2, 0); send(3'd3, 0); send(3'd4, 0);
    send(3'd5, 0); send(3'd6, 0);
    tick();

    // Rate 2/3: (5,6,00), (7,0,01), then -1 is A of the next group
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    rate_con = 4'b0001;
    send(3'd5, 0); send(3'd6, 0); send(3'd7, 0); send(3'b111, 0); send(3'd2, 0);
    tick();

    // SIGNAL override: 3/4 code with signal flag gives (-2,3,00), sig=1
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    rate_con = 4'b1111; signal_flag_in = 1'b1;
    send(3'b110, 0); send(3'd3, 0);
    signal_flag_in = 1'b0;

    // Mid-group rate change 3/4 -> 1/2 after the first bit is ignored
    rate_con = 4'b1111; send(3'd1, 0);
    rate_con = 4'b1101; send(3'd2, 0); send(3'd3, 0); send(3'd4, 0);
    tick();

    // Backpressure: pair0 pending, stall 5 clocks, then drain+load together
    rate_con = 4'b1111;
    send(3'd1, 0); send(3'd2, 0);
    dout_ready = 1'b0; din_valid = 1'b1; din = 3'd3;
    for (int i = 0; i < 5; i++) tick();
    dout_ready = 1'b1;
    send(3'd3, 0); send(3'd4, 0);
    tick();

    // din_last on the 3rd bit at 3/4 closes the frame with (3,0,01,last)
    frame_start = 1'b1;
    send(3'd1, 0); send(3'd2, 0); send(3'd3, 1);
    tick();

    // Asynchronous reset mid-group drops the collected bit
    send(3'd4, 0);
    #3 rst = 1'b1;
    #1 check_reset_outputs();
    m_valid = 1'b0; group_clear();
    @(posedge clk); #1 check_reset_outputs();
    rst = 1'b0;
    rate_con = 4'b1101;
    send(3'd6, 0); send(3'd7, 0);
    tick();

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      din_valid      = ($urandom_range(0, 3) != 0);
      din            = 3'($urandom);
      din_last       = ($urandom_range(0, 15) == 0);
      rate_con       = 4'($urandom);
      signal_flag_in = ($urandom_range(0, 9) == 0);
      frame_start    = ($urandom_range(0, 31) == 0);
      dout_ready     = ($urandom_range(0, 3) != 0);
      tick();
    end
    din_valid = 1'b0; frame_start = 1'b0; dout_ready = 1'b1;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
